// File: rtl/traj_pkg.sv
// Shared types and helpers for the trajectory overlay.
// Coordinates are carried at a fixed 16-bit width inside point_t.
package traj_pkg;

    localparam int COORD_MAX = 16;

    typedef logic [23:0] rgb_t;

    typedef struct packed {
        logic [COORD_MAX-1:0] h;
        logic [COORD_MAX-1:0] v;
        logic                 valid;
    } point_t;

    localparam point_t POINT_NONE = '{h: '1, v: '1, valid: 1'b0};

    // Signed distance with one extra bit so markers near 0 never wrap.
    function automatic logic in_box(
        input logic [COORD_MAX-1:0] h,
        input logic [COORD_MAX-1:0] v,
        input logic [COORD_MAX-1:0] ph,
        input logic [COORD_MAX-1:0] pv,
        input logic [COORD_MAX-1:0] half_w
    );
        logic signed [COORD_MAX:0] dh;
        logic signed [COORD_MAX:0] dv;
        logic signed [COORD_MAX:0] hw;
        dh = $signed({1'b0, h}) - $signed({1'b0, ph});
        dv = $signed({1'b0, v}) - $signed({1'b0, pv});
        hw = $signed({1'b0, half_w});
        if (dh < 0) dh = -dh;
        if (dv < 0) dv = -dv;
        return (dh <= hw) && (dv <= hw);
    endfunction

    function automatic logic [7:0] fade_green(
        input logic [7:0] age,
        input logic [8:0] step,
        input logic [8:0] floor_v
    );
        logic [16:0] drop;
        logic [8:0]  rem;
        drop = {9'd0, age} * {8'd0, step};
        if (drop >= 17'd255) begin
            rem = floor_v;
        end else begin
            rem = 9'd255 - drop[8:0];
            if (rem < floor_v) rem = floor_v;
        end
        return rem[7:0];
    endfunction

endpackage

// File: rtl/traj_ring.sv
// History ring of tracked points with a frame-synchronous staging register.
// Points are staged on strobe and committed only on frame start.
module traj_ring
    import traj_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int COORD_W = 10,
    localparam int PW     = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [COORD_W-1:0]  point_h,
    input  logic [COORD_W-1:0]  point_v,
    input  logic                point_val,
    input  logic                frame_start,
    input  logic                clear,
    output point_t [DEPTH-1:0]  entries,
    output logic   [PW-1:0]     wr_ptr
);

    point_t      staged;
    logic [PW:0] count;
    logic        commit;

    assign commit = frame_start && staged.valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            staged <= POINT_NONE;
            wr_ptr <= '0;
            count  <= '0;
            for (int k = 0; k < DEPTH; k++) entries[k] <= POINT_NONE;
        end else if (clear) begin
            staged <= POINT_NONE;
            wr_ptr <= '0;
            count  <= '0;
            for (int k = 0; k < DEPTH; k++) entries[k] <= POINT_NONE;
        end else begin
            if (commit) begin
                entries[wr_ptr] <= '{h: staged.h, v: staged.v, valid: 1'b1};
                wr_ptr          <= wr_ptr + PW'(1);
                if (count != (PW+1)'(DEPTH)) count <= count + 1'b1;
            end
            // A strobe in the commit cycle refills staging for the next frame.
            if (point_val) begin
                staged <= '{h: COORD_MAX'(point_h),
                            v: COORD_MAX'(point_v),
                            valid: 1'b1};
            end else if (commit) begin
                staged.valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/traj_history_overlay.sv
// Trajectory overlay: fading square markers around the last DEPTH points.
// Fixed 2-cycle pixel pipeline (hit compare, then priority select).
module traj_history_overlay
    import traj_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int HALF_W     = 1,
    parameter int COORD_W    = 10,
    parameter int FADE_STEP  = 32,
    parameter int FADE_FLOOR = 64
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [23:0]        i_color,
    input  logic [COORD_W-1:0] i_h,
    input  logic [COORD_W-1:0] i_v,
    input  logic               i_rendering,
    input  logic               i_frame_start,
    input  logic [COORD_W-1:0] i_point_h,
    input  logic [COORD_W-1:0] i_point_v,
    input  logic               i_point_val,
    input  logic               i_clear,
    input  logic               i_enable,
    output logic [23:0]        o_color,
    output logic               o_rendering
);

    localparam int PW = $clog2(DEPTH);

    point_t [DEPTH-1:0] entries;
    logic   [PW-1:0]    wr_ptr;

    traj_ring #(
        .DEPTH   (DEPTH),
        .COORD_W (COORD_W)
    ) u_ring (
        .clk         (i_clk),
        .rst_n       (i_rst_n),
        .point_h     (i_point_h),
        .point_v     (i_point_v),
        .point_val   (i_point_val),
        .frame_start (i_frame_start),
        .clear       (i_clear),
        .entries     (entries),
        .wr_ptr      (wr_ptr)
    );

    logic [DEPTH-1:0] hit;
    logic [DEPTH-1:0] hit_q;
    rgb_t             color_q;
    logic             rend_q;
    logic             en_q;
    logic [PW-1:0]    ptr_q;

    always_comb begin
        hit = '0;
        for (int k = 0; k < DEPTH; k++) begin
            hit[k] = entries[k].valid &&
                     in_box(COORD_MAX'(i_h), COORD_MAX'(i_v),
                            entries[k].h, entries[k].v,
                            COORD_MAX'(HALF_W));
        end
    end

    // Write pointer travels with the hits so ages match the compared set.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hit_q   <= '0;
            color_q <= '0;
            rend_q  <= 1'b0;
            en_q    <= 1'b0;
            ptr_q   <= '0;
        end else begin
            hit_q   <= hit;
            color_q <= i_color;
            rend_q  <= i_rendering;
            en_q    <= i_enable;
            ptr_q   <= wr_ptr;
        end
    end

    logic          found;
    logic [7:0]    sel_age;
    logic [PW-1:0] idx;
    rgb_t          marker;

    always_comb begin
        found   = 1'b0;
        sel_age = '0;
        idx     = '0;
        for (int a = DEPTH - 1; a >= 0; a--) begin
            idx = ptr_q - PW'(1) - PW'(a);
            if (hit_q[idx]) begin
                found   = 1'b1;
                sel_age = 8'(a);
            end
        end
        marker = {8'd0,
                  fade_green(sel_age, 9'(FADE_STEP), 9'(FADE_FLOOR)),
                  8'd0};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_color     <= '0;
            o_rendering <= 1'b0;
        end else begin
            o_color     <= (rend_q && en_q && found) ? marker : color_q;
            o_rendering <= rend_q;
        end
    end

endmodule
